wave_dac_sequencer: RTL and testbench
=====================================

WAVE_DAC_SEQUENCER -- requirements
Module: wave_dac_sequencer

Interface
REQ-001 SHALL have parameter CAPTURE_DELAY, default 2: clk cycles from sampling strobe to latching the channel words.
REQ-002 SHALL have parameter LDAC_WIDTH, default 4: clk cycles for which ldac_n is held low.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (100 MHz).
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port run, input, 1 bit: enables strobe generation.
REQ-006 SHALL have port sample_period, input, 16 bits: strobe period in clk cycles (2000 gives 50 kHz).
REQ-007 SHALL have ports enableA and enableB, input, 1 bit each: channel enables.
REQ-008 SHALL have ports dacA_word and dacB_word, input, 12 bits each: generator output words.
REQ-009 SHALL have port clk_sampling, output, 1 bit: one-cycle sampling strobe.
REQ-010 SHALL have port spi_valid, output, 1 bit: SPI command valid.
REQ-011 SHALL have port spi_data, output, 16 bits: SPI command word.
REQ-012 SHALL have port spi_ready, input, 1 bit: SPI master accepts a command.
REQ-013 SHALL have port spi_done, input, 1 bit: one-cycle pulse when a transfer completes.
REQ-014 SHALL have port ldac_n, output, 1 bit: DAC latch strobe, active-low.
REQ-015 SHALL have port overrun, output, 1 bit: sticky frame-overrun flag.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 Divider SHALL use a 16-bit counter: held at 0 while run=0; else increments, and at count >= eff_period-1 asserts clk_sampling for one cycle and returns to 0.
REQ-018 eff_period SHALL equal max(sample_period, 2), so a period of 0 or 1 behaves as 2.
REQ-019 A sample_period change SHALL apply without a restart; if the count already >= new eff_period-1, the strobe fires on the next cycle.
REQ-020 FSM states SHALL be IDLE, DELAY, SEND_A, WAIT_A, SEND_B, WAIT_B, LATCH.
REQ-021 IDLE -> DELAY on strobe when enableA or enableB is 1; otherwise stay IDLE with no SPI activity and no ldac_n pulse.
REQ-022 DELAY SHALL last CAPTURE_DELAY cycles, then capture dacA_word, dacB_word, enableA and enableB into registers.
- Exit to SEND_A if captured A enable = 1, else SEND_B.
REQ-023 SEND_A SHALL drive spi_valid=1 and spi_data={4'b0011, capA}.
- Hold both stable until spi_ready=1 in the same cycle; then go to WAIT_A with spi_valid=0 on the next cycle.
REQ-024 SEND_B SHALL behave as SEND_A with spi_data={4'b1011, capB}.
REQ-025 WAIT_A on spi_done SHALL go to SEND_B if captured B enable = 1, else LATCH; WAIT_B on spi_done SHALL go to LATCH.
REQ-026 spi_done SHALL be ignored outside the WAIT states.
REQ-027 LATCH SHALL drive ldac_n=0 for exactly LDAC_WIDTH cycles, then go to IDLE.
REQ-028 Frame latency SHALL be 1 + CAPTURE_DELAY cycles from strobe to the first spi_valid assertion.
REQ-029 A strobe while busy=1 SHALL still be emitted on clk_sampling and SHALL set overrun=1.
- That frame is dropped; the current frame completes unchanged.
REQ-030 overrun SHALL clear only on reset.
REQ-031 run falling mid-frame SHALL NOT abort the frame; only strobe generation stops.
REQ-032 spi_data SHALL be 0 whenever spi_valid=0.

Reset
REQ-033 On reset=1 at a clk edge, the following SHALL take effect next cycle regardless of state, aborting any frame:
- FSM=IDLE, divider=0, all captures=0.
- Outputs: clk_sampling=0, spi_valid=0, spi_data=0, ldac_n=1, overrun=0, busy=0.
REQ-034 After reset deasserts with run=1, the first strobe SHALL occur eff_period cycles later.

Verification
REQ-035 Period check: run=1, sample_period=2000 -> clk_sampling pulses exactly every 2000 cycles; sample_period=1 -> every 2 cycles.
REQ-036 Dual frame: enableA=enableB=1, dacA_word=0x123, dacB_word=0xABC, spi_ready=1, spi_done 10 cycles after each accept -> expect:
- spi_data 0x3123 then 0xB123+0x0999 (0xBABC);
- ldac_n low for 4 cycles;
- first spi_valid 3 cycles after strobe.
REQ-037 Single channel: enableA=0, enableB=1 -> only 0xBxxx sent, then LATCH; both disabled -> no spi_valid, ldac_n stays 1.
REQ-038 Backpressure: spi_ready=0 for 7 cycles -> spi_valid and spi_data held stable for 7 cycles; accepted on the 8th cycle.
REQ-039 Overrun: sample_period=20, spi_done withheld 50 cycles -> overrun=1, strobes continue every 20 cycles, one frame completes, and the next frame starts on the next strobe after IDLE.
REQ-040 Reset mid-frame: reset asserted in WAIT_B -> next cycle spi_valid=0, ldac_n=1, busy=0, overrun=0; the later spi_done is ignored.

Source files
------------

// File: rtl/wave_dac_sequencer.sv
// -----------------------------------------------------------------------------
// wave_dac_sequencer
//
// Generates a periodic sampling strobe and, on each strobe, sequences one
// dual-channel DAC update frame: wait for the generators to settle, capture
// both channel words, send one SPI command per enabled channel, then pulse
// the DAC latch (ldac_n) low.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   run            enables strobe generation
//   sample_period  strobe period in clk cycles (values below 2 act as 2)
//   enableA/B      channel enables
//   dacA/B_word    12-bit generator words
//   clk_sampling   one-cycle sampling strobe
//   spi_valid      SPI command valid
//   spi_data       SPI command word (0 while spi_valid is low)
//   spi_ready      SPI master accepts the command in this cycle
//   spi_done       one-cycle pulse at the end of a transfer
//   ldac_n         DAC latch strobe, active-low
//   overrun        sticky: a strobe arrived while a frame was in progress
//   busy           frame in progress
//
// CAPTURE_DELAY and LDAC_WIDTH must both be at least 1.
// -----------------------------------------------------------------------------
module wave_dac_sequencer #(
    parameter int unsigned CAPTURE_DELAY = 2,
    parameter int unsigned LDAC_WIDTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] sample_period,
    input  logic        enableA,
    input  logic        enableB,
    input  logic [11:0] dacA_word,
    input  logic [11:0] dacB_word,
    output logic        clk_sampling,
    output logic        spi_valid,
    output logic [15:0] spi_data,
    input  logic        spi_ready,
    input  logic        spi_done,
    output logic        ldac_n,
    output logic        overrun,
    output logic        busy
);

    localparam int TW = 16;
    localparam logic [TW-1:0] DLY_LAST = TW'(CAPTURE_DELAY - 1);
    localparam logic [TW-1:0] LAT_LAST = TW'(LDAC_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        SEND_A = 3'd2,
        WAIT_A = 3'd3,
        SEND_B = 3'd4,
        WAIT_B = 3'd5,
        LATCH  = 3'd6
    } state_t;

    // ---------------------------------------------------------------- divider
    logic [15:0] eff_period_s;
    logic        div_hit_s;
    logic [15:0] div_q, div_d;
    logic        strobe_q;

    assign eff_period_s = (sample_period < 16'd2) ? 16'd2 : sample_period;
    // ">=" rather than "==" so a shortened period fires on the next cycle
    assign div_hit_s    = run && (div_q >= (eff_period_s - 16'd1));

    // Divider next-count: held at zero while stopped, wraps on a strobe.
    always_comb begin
        div_d = div_q;
        if (!run) begin
            div_d = 16'd0;
        end else if (div_hit_s) begin
            div_d = 16'd0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Divider counter and registered strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= 16'd0;
            strobe_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            strobe_q <= div_hit_s;
        end
    end

    // -------------------------------------------------------------- frame FSM
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [11:0]   cap_a_q, cap_a_d;
    logic [11:0]   cap_b_q, cap_b_d;
    logic          cap_en_a_q, cap_en_a_d;
    logic          cap_en_b_q, cap_en_b_d;
    logic          overrun_q, overrun_d;
    logic          spi_valid_q, spi_valid_d;
    logic [15:0]   spi_data_q, spi_data_d;
    logic          ldac_n_q, ldac_n_d;
    logic          busy_q, busy_d;

    // Next-state, captures and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cap_a_d    = cap_a_q;
        cap_b_d    = cap_b_q;
        cap_en_a_d = cap_en_a_q;
        cap_en_b_d = cap_en_b_q;
        // a strobe seen while a frame is running is dropped and flagged
        overrun_d  = overrun_q | (strobe_q && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (strobe_q && (enableA || enableB)) begin
                    state_d = DELAY;
                    tmr_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (tmr_q == DLY_LAST) begin
                    cap_a_d    = dacA_word;
                    cap_b_d    = dacB_word;
                    cap_en_a_d = enableA;
                    cap_en_b_d = enableB;
                    state_d    = enableA ? SEND_A : SEND_B;
                    tmr_d      = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            SEND_A: begin
                if (spi_ready) begin
                    state_d = WAIT_A;
                end else begin
                    state_d = SEND_A;
                end
            end
            WAIT_A: begin
                if (spi_done) begin
                    if (cap_en_b_q) begin
                        state_d = SEND_B;
                    end else begin
                        state_d = LATCH;
                        tmr_d   = '0;
                    end
                end else begin
                    state_d = WAIT_A;
                end
            end
            SEND_B: begin
                if (spi_ready) begin
                    state_d = WAIT_B;
                end else begin
                    state_d = SEND_B;
                end
            end
            WAIT_B: begin
                if (spi_done) begin
                    state_d = LATCH;
                    tmr_d   = '0;
                end else begin
                    state_d = WAIT_B;
                end
            end
            LATCH: begin
                if (tmr_q == LAT_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        // outputs are registered from the next state so they line up with it
        spi_valid_d = (state_d == SEND_A) || (state_d == SEND_B);
        if (state_d == SEND_A) begin
            spi_data_d = {4'b0011, cap_a_d};
        end else if (state_d == SEND_B) begin
            spi_data_d = {4'b1011, cap_b_d};
        end else begin
            spi_data_d = 16'h0000;
        end
        ldac_n_d = (state_d != LATCH);
        busy_d   = (state_d != IDLE);
    end

    // Frame state, captures and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cap_a_q     <= 12'h000;
            cap_b_q     <= 12'h000;
            cap_en_a_q  <= 1'b0;
            cap_en_b_q  <= 1'b0;
            overrun_q   <= 1'b0;
            spi_valid_q <= 1'b0;
            spi_data_q  <= 16'h0000;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            cap_en_a_q  <= cap_en_a_d;
            cap_en_b_q  <= cap_en_b_d;
            overrun_q   <= overrun_d;
            spi_valid_q <= spi_valid_d;
            spi_data_q  <= spi_data_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
        end
    end

    assign clk_sampling = strobe_q;
    assign spi_valid    = spi_valid_q;
    assign spi_data     = spi_data_q;
    assign ldac_n       = ldac_n_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_wave_dac_sequencer.sv
// Self-checking bench for wave_dac_sequencer: every cycle the DUT outputs are
// compared against a transaction-level model (divider count plus a queue of
// pending SPI words); table-driven frame cases and hand-written corner-case
// sequences add explicit checks on top.
module tb_wave_dac_sequencer;

    localparam int CD = 2;
    localparam int LW = 4;
    localparam int MI = 0, MD = 1, MS = 2, MW = 3, ML = 4;

    logic        clk = 1'b0;
    logic        reset, run, enableA, enableB, spi_ready, spi_done;
    logic [15:0] sample_period;
    logic [11:0] dacA_word, dacB_word;
    logic        clk_sampling, spi_valid, ldac_n, overrun, busy;
    logic [15:0] spi_data;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // reference model state
    int          m_cnt;
    bit          m_strobe;
    bit          m_ovr;
    int          m_mode;
    int          m_left;
    logic [15:0] m_q[$];

    wave_dac_sequencer #(.CAPTURE_DELAY(CD), .LDAC_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .run(run), .sample_period(sample_period),
        .enableA(enableA), .enableB(enableB), .dacA_word(dacA_word), .dacB_word(dacB_word),
        .clk_sampling(clk_sampling), .spi_valid(spi_valid), .spi_data(spi_data),
        .spi_ready(spi_ready), .spi_done(spi_done), .ldac_n(ldac_n),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, using the inputs of this cycle.
    task automatic model_step();
        int eff;
        if (reset) begin
            m_cnt = 0; m_strobe = 0; m_ovr = 0; m_mode = MI; m_left = 0;
            m_q.delete();
            return;
        end
        if (m_strobe && m_mode != MI) m_ovr = 1;
        case (m_mode)
            MI: if (m_strobe && (enableA || enableB)) begin m_mode = MD; m_left = CD; end
            MD: begin
                m_left--;
                if (m_left == 0) begin
                    m_q.delete();
                    if (enableA) m_q.push_back({4'h3, dacA_word});
                    if (!enableA || enableB) m_q.push_back({4'hB, dacB_word});
                    m_mode = MS;
                end
            end
            MS: if (spi_ready) begin m_q.delete(0); m_mode = MW; end
            MW: if (spi_done) begin
                if (m_q.size() > 0) m_mode = MS;
                else begin m_mode = ML; m_left = LW; end
            end
            ML: begin m_left--; if (m_left == 0) m_mode = MI; end
            default: m_mode = MI;
        endcase
        eff = (sample_period < 16'd2) ? 2 : int'(sample_period);
        if (!run) begin
            m_strobe = 0; m_cnt = 0;
        end else if (m_cnt >= eff - 1) begin
            m_strobe = 1; m_cnt = 0;
        end else begin
            m_strobe = 0; m_cnt++;
        end
    endtask

    task automatic check_all();
        logic e_valid;
        e_valid = (m_mode == MS);
        chk1("m_strobe", clk_sampling, m_strobe);
        chk1("m_valid", spi_valid, e_valid);
        chk16("m_data", spi_data, e_valid ? m_q[0] : 16'h0000);
        chk1("m_ldac_n", ldac_n, m_mode != ML);
        chk1("m_overrun", overrun, m_ovr);
        chk1("m_busy", busy, m_mode != MI);
    endtask

    // advance one cycle: model follows the edge, outputs checked at negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin tick(); n++; end while (!clk_sampling && n < limit);
        if (!clk_sampling) begin
            n_assert++; n_fail++;
            $display("FAIL strobe_timeout: no clk_sampling within %0d cycles", limit);
        end
    endtask

    // Serve one frame with spi_ready=1 and spi_done 10 cycles after each accept.
    task automatic frame_run(output int lat, output int nw, output logic [15:0] w0,
                             output logic [15:0] w1, output int low);
        int timer;
        lat = -1; nw = 0; low = 0; timer = 0; w0 = 16'h0; w1 = 16'h0;
        spi_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (spi_valid && lat < 0) lat = i;
            if (!ldac_n) low++;
            spi_done = 1'b0;
            if (timer > 0) begin timer--; if (timer == 0) spi_done = 1'b1; end
            if (spi_valid && spi_ready) begin
                if (nw == 0) w0 = spi_data;
                if (nw == 1) w1 = spi_data;
                nw++;
                timer = 10;
            end
        end
        spi_done = 1'b0;
    endtask

    typedef struct {
        logic        en_a;
        logic        en_b;
        logic [11:0] wa;
        logic [11:0] wb;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, lat, nw, low, last, cnt, acc;
        logic [15:0] w0, w1;

        vecs[0] = '{1'b1, 1'b1, 12'h123, 12'hABC, 2, 16'h3123, 16'hBABC};
        vecs[1] = '{1'b0, 1'b1, 12'h555, 12'h0F0, 1, 16'hB0F0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 12'hFFF, 12'h001, 1, 16'h3FFF, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 12'h111, 12'h222, 0, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 12'h000, 12'hFFF, 2, 16'h3000, 16'hBFFF};

        reset = 1'b1; run = 1'b0; sample_period = 16'd2000;
        enableA = 1'b0; enableB = 1'b0; dacA_word = 12'h0; dacB_word = 12'h0;
        spi_ready = 1'b0; spi_done = 1'b0;
        do_reset();

        // reset state
        chk1("rst_strobe", clk_sampling, 1'b0);
        chk1("rst_valid", spi_valid, 1'b0);
        chk16("rst_data", spi_data, 16'h0000);
        chk1("rst_ldac_n", ldac_n, 1'b1);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_busy", busy, 1'b0);

        // strobe periods: first strobe eff_period cycles after reset, then steady
        run = 1'b1;
        sample_period = 16'd2000; do_reset();
        wait_strobe(2100, n); chki("period2000_first", n, 2000);
        wait_strobe(2100, n); chki("period2000", n, 2000);
        sample_period = 16'd1; do_reset();
        wait_strobe(10, n); chki("period1_first", n, 2);
        wait_strobe(10, n); chki("period1", n, 2);
        sample_period = 16'd0; do_reset();
        wait_strobe(10, n); chki("period0", n, 2);

        // table-driven frames
        sample_period = 16'd150;
        for (int v = 0; v < 5; v++) begin
            enableA = vecs[v].en_a; enableB = vecs[v].en_b;
            dacA_word = vecs[v].wa; dacB_word = vecs[v].wb;
            do_reset();
            wait_strobe(200, n);
            frame_run(lat, nw, w0, w1, low);
            chki("vec_nwords", nw, vecs[v].nw);
            if (vecs[v].nw >= 1) begin
                chk16("vec_word0", w0, vecs[v].w0);
                chki("vec_latency", lat, 1 + CD);
            end
            if (vecs[v].nw >= 2) chk16("vec_word1", w1, vecs[v].w1);
            chki("vec_ldac_low", low, (vecs[v].nw > 0) ? LW : 0);
            chk1("vec_idle", busy, 1'b0);
        end

        // backpressure: 7 cycles not ready, accepted on the 8th
        enableA = 1'b1; enableB = 1'b0; dacA_word = 12'h5A5; spi_ready = 1'b0;
        do_reset();
        wait_strobe(200, n);
        n = 0;
        while (!spi_valid && n < 10) begin tick(); n++; end
        for (int k = 1; k <= 7; k++) begin
            chk1("bp_valid", spi_valid, 1'b1);
            chk16("bp_data", spi_data, 16'h35A5);
            tick();
        end
        chk1("bp_valid8", spi_valid, 1'b1);
        chk16("bp_data8", spi_data, 16'h35A5);
        spi_ready = 1'b1;
        tick();
        chk1("bp_accepted", spi_valid, 1'b0);
        chk16("bp_data_zero", spi_data, 16'h0000);
        spi_done = 1'b1; tick(); spi_done = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk1("bp_idle", busy, 1'b0);

        // overrun: spi_done withheld while strobes keep coming every 20 cycles
        enableA = 1'b1; enableB = 1'b1; dacA_word = 12'h321; dacB_word = 12'h654;
        sample_period = 16'd20; spi_ready = 1'b1;
        do_reset();
        wait_strobe(30, n);
        last = 0; cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (clk_sampling) begin chki("ovr_interval", i - last, 20); last = i; cnt++; end
        end
        chki("ovr_strobe_count", cnt, 2);
        chk1("ovr_flag", overrun, 1'b1);
        spi_done = 1'b1; tick(); spi_done = 1'b0;
        n = 0;
        while (!spi_valid && n < 10) begin tick(); n++; end
        chk16("ovr_word_b", spi_data, 16'hB654);
        tick();
        spi_done = 1'b1; tick(); spi_done = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk1("ovr_frame_done", busy, 1'b0);
        wait_strobe(25, n);
        tick(); tick();
        chk1("ovr_next_lat2", spi_valid, 1'b0);
        tick();
        chk1("ovr_next_lat3", spi_valid, 1'b1);
        chk1("ovr_sticky", overrun, 1'b1);

        // reset while in WAIT_B (with overrun already set)
        do_reset();
        wait_strobe(30, n);
        acc = 0; n = 0;
        while (acc < 2 && n < 80) begin
            tick(); n++;
            if (spi_valid && spi_ready) begin
                acc++;
                if (acc == 1) begin
                    for (int k = 0; k < 25; k++) tick();
                    spi_done = 1'b1; tick(); spi_done = 1'b0;
                end
            end
        end
        tick();
        chk1("rmf_in_frame", busy, 1'b1);
        chk1("rmf_overrun_pre", overrun, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk1("rmf_valid", spi_valid, 1'b0);
        chk1("rmf_ldac_n", ldac_n, 1'b1);
        chk1("rmf_busy", busy, 1'b0);
        chk1("rmf_overrun", overrun, 1'b0);
        spi_done = 1'b1; tick(); spi_done = 1'b0;
        tick();
        chk1("rmf_done_ignored", busy, 1'b0);
        chk1("rmf_ldac_idle", ldac_n, 1'b1);

        // randomized stimulus, checked every cycle against the model
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 49) == 0) run = ~run;
            if ($urandom_range(0, 99) == 0) sample_period = 16'($urandom_range(0, 30));
            if ($urandom_range(0, 39) == 0) enableA = ~enableA;
            if ($urandom_range(0, 39) == 0) enableB = ~enableB;
            dacA_word = 12'($urandom);
            dacB_word = 12'($urandom);
            spi_ready = ($urandom_range(0, 2) != 0);
            spi_done  = ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
